main_mem: RTL and testbench

Line-granular backing memory placed directly downstream of the L1 data cache. It accepts one 128-bit line read or write from the cache controller's memory request channel and completes it after a fixed, parameterized latency. Completion is signalled with a one-cycle ready pulse, and read data comes back on the memory data channel. The block serves as the next level of the hierarchy for the 4-way L1, both in simulation and in integration.

---
 rtl/main_mem.sv | 108 ++++++++++
 tb/tb_main_mem.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/main_mem.sv
`default_nettype none
// ============================================================================
// main_mem : line-granular backing memory behind the L1 data cache; accepts
//            one 128-bit read or write and completes it after LATENCY cycles.
// Revision : 1.0
// ============================================================================
module main_mem #(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  req_addr_i,
    input  logic [127:0] req_data_i,
    input  logic         req_rw_i,
    input  logic         req_valid_i,
    output logic [127:0] res_data_o,
    output logic         res_ready_o,
    output logic         busy_o,
    output logic [31:0]  no_rd_o,
    output logic [31:0]  no_wr_o
);

    localparam int C_IDX_W = $clog2(DEPTH_LINES);
    localparam int C_CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = (LATENCY > 1) ? C_CNT_W'(LATENCY - 2) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_IDX_W-1:0] r_idx;
    logic [127:0]       r_data;
    logic               r_rw;
    logic [127:0]       r_res_data;
    logic [31:0]        r_no_rd;
    logic [31:0]        r_no_wr;

    // Contents start at zero and survive rst_i.
    logic [127:0]       r_mem [DEPTH_LINES] = '{default: '0};

    logic               w_accept;
    logic               w_to_done;
    logic [C_IDX_W-1:0] w_idx;
    logic [127:0]       w_data;
    logic               w_rw;
    logic               w_unused_addr;

    assign w_unused_addr = ^{req_addr_i[31:C_IDX_W+4], req_addr_i[3:0]};

    assign w_accept  = (r_state == S_IDLE) && req_valid_i;
    assign w_to_done = (w_accept && (LATENCY == 1)) ||
                       ((r_state == S_BUSY) && (r_cnt == '0));

    // With LATENCY=1 the array is touched on the accepting edge, before the latches hold anything.
    assign w_idx  = (r_state == S_IDLE) ? req_addr_i[C_IDX_W+3:4] : r_idx;
    assign w_data = (r_state == S_IDLE) ? req_data_i : r_data;
    assign w_rw   = (r_state == S_IDLE) ? req_rw_i   : r_rw;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_rw       <= 1'b0;
            r_res_data <= '0;
            r_no_rd    <= '0;
            r_no_wr    <= '0;
        end else begin
            r_res_data <= (w_to_done && !w_rw) ? r_mem[w_idx] : '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_idx  <= req_addr_i[C_IDX_W+3:4];
                        r_data <= req_data_i;
                        r_rw   <= req_rw_i;
                        r_cnt  <= C_CNT_LOAD;
                        if (req_rw_i) r_no_wr <= r_no_wr + 32'd1;
                        else          r_no_rd <= r_no_rd + 32'd1;
                        r_state <= (LATENCY == 1) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) r_state <= S_DONE;
                    else             r_cnt   <= r_cnt - C_CNT_W'(1);
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A write cut short by reset never reaches the array.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_to_done && w_rw) r_mem[w_idx] <= w_data;
    end

    assign res_data_o  = r_res_data;
    assign res_ready_o = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);
    assign no_rd_o     = r_no_rd;
    assign no_wr_o     = r_no_wr;

endmodule
`default_nettype wire

// File: tb/tb_main_mem.sv
`default_nettype none
// ============================================================================
// tb_main_mem : scoreboard bench for main_mem, one LATENCY=8 and one
//               LATENCY=1 instance exercised in turn.
// Revision    : 1.0
// ============================================================================
module tb_main_mem;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 8;
    localparam int LAT1  = 1;

    typedef struct {
        int           k;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    int           cyc = 0;
    logic         mon_en = 1'b0;
    int           checks = 0;
    int           passes = 0;

    logic         rst   [2];
    logic         valid [2];
    logic         rw    [2];
    logic [31:0]  addr  [2];
    logic [127:0] wdata [2];
    logic [127:0] rdata [2];
    logic         ready [2];
    logic         busy  [2];
    logic [31:0]  nrd   [2];
    logic [31:0]  nwr   [2];

    exp_t         sbq[$];
    logic [127:0] mm[int];
    int           bfrom[2], bto[2], next_free[2], rd_m[2], wr_m[2];

    main_mem #(.DEPTH_LINES(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .req_addr_i(addr[0]), .req_data_i(wdata[0]),
        .req_rw_i(rw[0]), .req_valid_i(valid[0]), .res_data_o(rdata[0]),
        .res_ready_o(ready[0]), .busy_o(busy[0]), .no_rd_o(nrd[0]), .no_wr_o(nwr[0])
    );

    main_mem #(.DEPTH_LINES(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .req_addr_i(addr[1]), .req_data_i(wdata[1]),
        .req_rw_i(rw[1]), .req_valid_i(valid[1]), .res_data_o(rdata[1]),
        .res_ready_o(ready[1]), .busy_o(busy[1]), .no_rd_o(nrd[1]), .no_wr_o(nwr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard on every ready pulse, checks idle outputs otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (ready[k] === 1'b1) begin
                    if (sbq.size() == 0 || sbq[0].k != k) begin
                        checks++;
                        $display("FAIL unexpected_ready: dut%0d pulsed with no request pending (cycle %0d)", k, cyc);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("res_data", rdata[k], e.data);
                        chk("ready_cycle", cyc, e.cyc);
                    end
                end else begin
                    chk("idle_data_zero", rdata[k], '0);
                end
                chk("busy", busy[k], (cyc >= bfrom[k] && cyc <= bto[k]));
            end
        end
    end

    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [127:0] d, input bit last);
        int t, n, key;
        logic [127:0] exp;
        t   = (cyc > next_free[k]) ? cyc : next_free[k];
        key = k * DEPTH + int'((a >> 4) % DEPTH);
        if (w) begin
            mm[key] = d;
            exp = '0;
            wr_m[k]++;
        end else begin
            exp = mm.exists(key) ? mm[key] : '0;
            rd_m[k]++;
        end
        sbq.push_back('{k: k, data: exp, cyc: t + lat_of(k)});
        bfrom[k] = t + 1;
        bto[k] = t + lat_of(k);
        next_free[k] = t + lat_of(k) + 1;
        valid[k] = 1'b1; rw[k] = w; addr[k] = a; wdata[k] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            // Request fields change after acceptance; valid stays high through DONE.
            if (cyc > t) begin
                addr[k] = $urandom; wdata[k] = {4{$urandom}}; rw[k] = ~w;
            end
        end while (ready[k] !== 1'b1 && n < 40);
        if (n >= 40) begin
            checks++;
            $display("FAIL ready_timeout: dut%0d got no ready expected one by cycle %0d", k, t + lat_of(k));
        end
        @(posedge clk); #1;
        chk("no_rd", nrd[k], rd_m[k]);
        chk("no_wr", nwr[k], wr_m[k]);
        if (last) valid[k] = 1'b0;
    endtask

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D3 = 128'hA5A5_5A5A_FFFF_0000_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D4 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D5 = 128'hFEDC_BA98_7654_3210_0F0F_F0F0_CAFE_F00D;
    localparam logic [127:0] DX = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

    initial begin
        int t;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; valid[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            bfrom[k] = 1; bto[k] = 0; next_free[k] = 0; rd_m[k] = 0; wr_m[k] = 0;
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst[0] = 1'b0; rst[1] = 1'b0;
        chk("reset_no_rd", nrd[0], '0);
        chk("reset_no_wr", nwr[0], '0);

        // Write then read back, then two aliases of the same line.
        issue(0, 1'b1, 32'h0000_0010, D1, 1'b1);
        issue(0, 1'b0, 32'h0000_0010, '0, 1'b1);
        issue(0, 1'b0, 32'h0000_001F, '0, 1'b0);
        issue(0, 1'b0, 32'h0000_0010 + 32'(16 * DEPTH), '0, 1'b1);

        // Back-to-back alternating traffic with valid held through DONE.
        issue(0, 1'b1, 32'h0000_0050, D2, 1'b0);
        issue(0, 1'b0, 32'h0000_0050, '0, 1'b0);
        issue(0, 1'b1, 32'h0000_0054, D3, 1'b0);
        issue(0, 1'b0, 32'h0000_0058, '0, 1'b1);
        @(posedge clk); #1;

        // Reset three cycles into a write: the write is dropped and counters clear.
        t = cyc;
        valid[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h0000_0020; wdata[0] = DX;
        bfrom[0] = t + 1; bto[0] = t + 3;
        while (cyc < t + 3) begin @(posedge clk); #1; end
        rst[0] = 1'b1; valid[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rd_m[0] = 0; wr_m[0] = 0; next_free[0] = cyc;
        chk("midreset_no_rd", nrd[0], '0);
        chk("midreset_no_wr", nwr[0], '0);
        issue(0, 1'b0, 32'h0000_0020, '0, 1'b1);

        // Reset coinciding with a request in IDLE: nothing is accepted.
        rst[0] = 1'b1; valid[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h0000_0030; wdata[0] = DX;
        @(posedge clk); #1;
        rst[0] = 1'b0; valid[0] = 1'b0;
        rd_m[0] = 0; wr_m[0] = 0; next_free[0] = cyc;
        repeat (3) begin @(posedge clk); #1; end
        chk("rstvalid_no_wr", nwr[0], '0);
        issue(0, 1'b0, 32'h0000_0030, '0, 1'b1);

        // LATENCY=1 instance: single read, then alternating back-to-back pairs.
        issue(1, 1'b0, 32'h0000_0040, '0, 1'b1);
        @(posedge clk); #1;
        issue(1, 1'b1, 32'h0000_0040, D4, 1'b0);
        issue(1, 1'b0, 32'h0000_0040, '0, 1'b0);
        issue(1, 1'b1, 32'h0000_0080, D5, 1'b0);
        issue(1, 1'b0, 32'h0000_0080, '0, 1'b1);

        repeat (12) begin @(posedge clk); #1; end
        chk("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
